// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin or fixed-priority grant, one-entry registered response.
package alu_arbiter_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;

endpackage

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter bit          RR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            r0_valid,
   output logic            r0_ready,
   input  logic            r0_is_r,
   input  logic [XLEN-1:0] r0_rs1,
   input  logic [XLEN-1:0] r0_rs2,
   input  logic [XLEN-1:0] r0_imm32,
   input  alu_op_e         r0_op,

   input  logic            r1_valid,
   output logic            r1_ready,
   input  logic            r1_is_r,
   input  logic [XLEN-1:0] r1_rs1,
   input  logic [XLEN-1:0] r1_rs2,
   input  logic [XLEN-1:0] r1_imm32,
   input  alu_op_e         r1_op,

   output logic            alu_is_r,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic [XLEN-1:0] alu_imm32,
   output alu_op_e         alu_op,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_branch_taken,

   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_branch,
   output logic [15:0]     op_count
);

   logic full;
   logic drain;
   logic can_accept;
   logic any_req;
   logic win1;
   logic grant;
   logic last_grant;

   // A held response frees the buffer in the same cycle its owner takes it
   assign full       = rsp0_valid | rsp1_valid;
   assign drain      = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   assign can_accept = !rst && (!full || drain);
   assign any_req    = r0_valid | r1_valid;
   assign grant      = can_accept & any_req;

   assign r0_ready = grant & !win1;
   assign r1_ready = grant &  win1;

   // Winner select: lone requester wins, contention by policy
   always_comb begin
      win1 = 1'b0;
      unique case (1'b1)
         (r0_valid && r1_valid): win1 = RR_EN ? !last_grant : 1'b0;
         (r1_valid && !r0_valid): win1 = 1'b1;
         default: win1 = 1'b0;
      endcase
   end

   // ALU operand mux; idle drives a clean ADD of zeros
   always_comb begin
      alu_is_r  = 1'b0;
      alu_rs1   = '0;
      alu_rs2   = '0;
      alu_imm32 = '0;
      alu_op    = ALU_ADD;
      if (grant) begin
         if (win1) begin
            alu_is_r  = r1_is_r;
            alu_rs1   = r1_rs1;
            alu_rs2   = r1_rs2;
            alu_imm32 = r1_imm32;
            alu_op    = r1_op;
         end else begin
            alu_is_r  = r0_is_r;
            alu_rs1   = r0_rs1;
            alu_rs2   = r0_rs2;
            alu_imm32 = r0_imm32;
            alu_op    = r0_op;
         end
      end
   end

   // Response buffer, grant history and completion counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= '0;
         rsp_branch <= 1'b0;
         op_count   <= 16'd0;
         last_grant <= 1'b1;
      end else begin
         if (drain) begin
            op_count <= op_count + 16'd1;
         end
         if (grant) begin
            rsp_result <= alu_result;
            rsp_branch <= (alu_op == ALU_SUB) ? alu_branch_taken : 1'b0;
            rsp0_valid <= !win1;
            rsp1_valid <= win1;
            if (RR_EN) begin
               last_grant <= win1;
            end
         end else if (drain) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors plus scoreboarded sequences.
// Two instances: round-robin (a) and fixed priority (b).
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   typedef struct {
      bit          owner;
      logic [31:0] res;
      logic        br;
   } exp_t;

   typedef struct {
      bit          id;
      alu_op_e     op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      bit          is_r;
      logic [31:0] res;
      logic        br;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r0_valid = 1'b0, r1_valid = 1'b0;
   logic        r0_is_r = 1'b0, r1_is_r = 1'b0;
   logic [31:0] r0_rs1 = '0, r0_rs2 = '0, r0_imm32 = '0;
   logic [31:0] r1_rs1 = '0, r1_rs2 = '0, r1_imm32 = '0;
   alu_op_e     r0_op = ALU_ADD, r1_op = ALU_ADD;
   logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

   logic        r0_ready_a, r1_ready_a, r0_ready_b, r1_ready_b;
   logic        alu_is_r_a, alu_is_r_b;
   logic [31:0] alu_rs1_a, alu_rs2_a, alu_imm32_a;
   logic [31:0] alu_rs1_b, alu_rs2_b, alu_imm32_b;
   alu_op_e     alu_op_a, alu_op_b;
   logic [31:0] alu_result_a, alu_result_b;
   logic        alu_bt_a, alu_bt_b;
   logic        rsp0_valid_a, rsp1_valid_a, rsp0_valid_b, rsp1_valid_b;
   logic [31:0] rsp_result_a, rsp_result_b;
   logic        rsp_branch_a, rsp_branch_b;
   logic [15:0] op_count_a, op_count_b;

   int   tests = 0;
   int   fails = 0;
   bit   auto_push = 1'b1;
   exp_t q[$];
   vec_t tv [8];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(alu_op_e op, logic [31:0] a,
                                        logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Environment ALU: branch is equality on SUB, junk high otherwise
   assign alu_result_a = alu_f(alu_op_a, alu_rs1_a,
                               alu_is_r_a ? alu_rs2_a : alu_imm32_a);
   assign alu_bt_a = (alu_op_a == ALU_SUB) ? (alu_result_a == 32'd0) : 1'b1;
   assign alu_result_b = alu_f(alu_op_b, alu_rs1_b,
                               alu_is_r_b ? alu_rs2_b : alu_imm32_b);
   assign alu_bt_b = (alu_op_b == ALU_SUB) ? (alu_result_b == 32'd0) : 1'b1;

   alu_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready_a), .r0_is_r(r0_is_r),
      .r0_rs1(r0_rs1), .r0_rs2(r0_rs2), .r0_imm32(r0_imm32), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready_a), .r1_is_r(r1_is_r),
      .r1_rs1(r1_rs1), .r1_rs2(r1_rs2), .r1_imm32(r1_imm32), .r1_op(r1_op),
      .alu_is_r(alu_is_r_a), .alu_rs1(alu_rs1_a), .alu_rs2(alu_rs2_a),
      .alu_imm32(alu_imm32_a), .alu_op(alu_op_a),
      .alu_result(alu_result_a), .alu_branch_taken(alu_bt_a),
      .rsp0_valid(rsp0_valid_a), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid_a), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result_a), .rsp_branch(rsp_branch_a),
      .op_count(op_count_a)
   );

   alu_arbiter #(.XLEN(32), .RR_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready_b), .r0_is_r(r0_is_r),
      .r0_rs1(r0_rs1), .r0_rs2(r0_rs2), .r0_imm32(r0_imm32), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready_b), .r1_is_r(r1_is_r),
      .r1_rs1(r1_rs1), .r1_rs2(r1_rs2), .r1_imm32(r1_imm32), .r1_op(r1_op),
      .alu_is_r(alu_is_r_b), .alu_rs1(alu_rs1_b), .alu_rs2(alu_rs2_b),
      .alu_imm32(alu_imm32_b), .alu_op(alu_op_b),
      .alu_result(alu_result_b), .alu_branch_taken(alu_bt_b),
      .rsp0_valid(rsp0_valid_b), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid_b), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result_b), .rsp_branch(rsp_branch_b),
      .op_count(op_count_b)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(bit id);
      exp_t e;
      alu_op_e op;
      logic [31:0] a, b;
      op = id ? r1_op : r0_op;
      a  = id ? r1_rs1 : r0_rs1;
      if (id) b = r1_is_r ? r1_rs2 : r1_imm32;
      else    b = r0_is_r ? r0_rs2 : r0_imm32;
      e.owner = id;
      e.res   = alu_f(op, a, b);
      e.br    = (op == ALU_SUB) && (a == b);
      return e;
   endfunction

   // Sample after inputs settle; record accepted requests
   task automatic settle();
      #1;
      if (auto_push) begin
         if (r0_valid && r0_ready_a) q.push_back(model(1'b0));
         if (r1_valid && r1_ready_a) q.push_back(model(1'b1));
      end
   endtask

   task automatic set_req(bit id, alu_op_e op, logic [31:0] a,
                          logic [31:0] b, logic [31:0] imm, bit is_r);
      if (id) begin
         r1_valid = 1'b1; r1_op = op; r1_rs1 = a;
         r1_rs2 = b; r1_imm32 = imm; r1_is_r = is_r;
      end else begin
         r0_valid = 1'b1; r0_op = op; r0_rs1 = a;
         r0_rs2 = b; r0_imm32 = imm; r0_is_r = is_r;
      end
   endtask

   task automatic pop_check(bit id);
      exp_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL sb_empty: response on rsp%0d with nothing expected", id);
      end else begin
         e = q.pop_front();
         if (e.owner != id || rsp_result_a !== e.res || rsp_branch_a !== e.br) begin
            fails++;
            $display("FAIL sb_rsp: got rsp%0d res=%h br=%b expected rsp%0d res=%h br=%b",
                     id, rsp_result_a, rsp_branch_a, e.owner, e.res, e.br);
         end
      end
   endtask

   // Response monitor: pops the scoreboard on every handshake
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (rsp0_valid_a && rsp0_ready) pop_check(1'b0);
         if (rsp1_valid_a && rsp1_ready) pop_check(1'b1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{1'b0, ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b0, 32'd12, 1'b0};
      tv[1] = '{1'b1, ALU_SUB, 32'h10, 32'h10, 32'd0, 1'b1, 32'd0, 1'b1};
      tv[2] = '{1'b1, ALU_XOR, 32'hF0, 32'hFF, 32'd0, 1'b1, 32'h0F, 1'b0};
      tv[3] = '{1'b0, ALU_SUB, 32'd5, 32'd0, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0};
      tv[4] = '{1'b0, ALU_AND, 32'hF0F0, 32'hFF00, 32'd0, 1'b1, 32'hF000, 1'b0};
      tv[5] = '{1'b1, ALU_OR, 32'h0F, 32'd0, 32'h30, 1'b0, 32'h3F, 1'b0};
      tv[6] = '{1'b0, ALU_SUB, 32'h8000_0000, 32'd0, 32'd1, 1'b0,
                32'h7FFF_FFFF, 1'b0};
      tv[7] = '{1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 32'd0, 1'b0};

      // Reset: ready must stay low while rst is high
      @(negedge clk); rst = 1'b1; r0_valid = 1'b1; settle();
      chk("ready_in_rst", r0_ready_a, 1'b0);
      @(negedge clk); r0_valid = 1'b0; settle();
      @(negedge clk); rst = 1'b0; settle();
      chk("rst_rsp0_valid", rsp0_valid_a, 1'b0);
      chk("rst_rsp1_valid", rsp1_valid_a, 1'b0);
      chk("rst_result", rsp_result_a, 32'd0);
      chk("rst_branch", rsp_branch_a, 1'b0);
      chk("rst_op_count", op_count_a, 16'd0);

      // Table vectors: one lone request each, response next cycle
      auto_push = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         @(negedge clk);
         r0_valid = 1'b0; r1_valid = 1'b0;
         set_req(tv[i].id, tv[i].op, tv[i].rs1, tv[i].rs2,
                 tv[i].imm, tv[i].is_r);
         settle();
         chk($sformatf("v%0d_op_count", i), op_count_a, i);
         chk($sformatf("v%0d_ready", i),
             tv[i].id ? r1_ready_a : r0_ready_a, 1'b1);
         chk($sformatf("v%0d_loser_ready", i),
             tv[i].id ? r0_ready_a : r1_ready_a, 1'b0);
         e.owner = tv[i].id; e.res = tv[i].res; e.br = tv[i].br;
         q.push_back(e);
         @(negedge clk);
         r0_valid = 1'b0; r1_valid = 1'b0;
         settle();
         chk($sformatf("v%0d_rsp_valid", i),
             tv[i].id ? rsp1_valid_a : rsp0_valid_a, 1'b1);
         chk($sformatf("v%0d_rsp_other", i),
             tv[i].id ? rsp0_valid_a : rsp1_valid_a, 1'b0);
         chk($sformatf("v%0d_idle_alu", i),
             {alu_op_a, alu_is_r_a, alu_rs1_a | alu_rs2_a | alu_imm32_a},
             {ALU_ADD, 1'b0, 32'd0});
      end
      auto_push = 1'b1;

      // Contention: RR alternates 0,1,0,1; fixed priority always 0
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_req(1'b0, ALU_ADD, 32'd100 + k, 32'd0, 32'd1, 1'b0);
         set_req(1'b1, ALU_SUB, 32'd50, 32'd0, k, 1'b0);
         settle();
         chk($sformatf("rr%0d_r0_ready", k), r0_ready_a, (k % 2) == 0);
         chk($sformatf("rr%0d_r1_ready", k), r1_ready_a, (k % 2) == 1);
         chk($sformatf("fp%0d_r0_ready", k), r0_ready_b, 1'b1);
         chk($sformatf("fp%0d_r1_ready", k), r1_ready_b, 1'b0);
         if (k > 0) begin
            chk($sformatf("rr%0d_rsp0_valid", k), rsp0_valid_a, (k % 2) == 1);
            chk($sformatf("rr%0d_rsp1_valid", k), rsp1_valid_a, (k % 2) == 0);
         end
      end
      @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0; settle();

      // Back-pressure: rsp0 held, both stall, then drain plus refill
      @(negedge clk);
      rsp0_ready = 1'b0;
      set_req(1'b0, ALU_ADD, 32'd3, 32'd0, 32'd4, 1'b0);
      settle();
      chk("bp_first_accept", r0_ready_a, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_req(1'b1, ALU_SUB, 32'h20, 32'd0, 32'h8, 1'b0);
         settle();
         chk($sformatf("bp%0d_readies", k), {r0_ready_a, r1_ready_a}, 2'b00);
         chk($sformatf("bp%0d_rsp0_held", k), rsp0_valid_a, 1'b1);
         chk($sformatf("bp%0d_result", k), rsp_result_a, 32'd7);
      end
      @(negedge clk);
      rsp0_ready = 1'b1;
      settle();
      chk("bp_refill_r1", r1_ready_a, 1'b1);
      chk("bp_refill_r0", r0_ready_a, 1'b0);
      @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0; settle();
      chk("bp_rsp1_valid", rsp1_valid_a, 1'b1);
      @(negedge clk); settle();

      // Reset while a response is held for requester 1
      @(negedge clk);
      rsp1_ready = 1'b0;
      set_req(1'b1, ALU_SUB, 32'h33, 32'h33, 32'd0, 1'b1);
      settle();
      @(negedge clk);
      r1_valid = 1'b0; r0_valid = 1'b1; rsp1_ready = 1'b1; rst = 1'b1;
      settle();
      chk("mid_rst_held", rsp1_valid_a, 1'b1);
      chk("mid_rst_ready", r0_ready_a, 1'b0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      set_req(1'b0, ALU_OR, 32'h1, 32'd0, 32'h2, 1'b0);
      set_req(1'b1, ALU_AND, 32'hF, 32'd0, 32'h3, 1'b0);
      settle();
      chk("post_rst_valids", {rsp0_valid_a, rsp1_valid_a}, 2'b00);
      chk("post_rst_count", op_count_a, 16'd0);
      chk("post_rst_grant", {r0_ready_a, r1_ready_a}, 2'b10);
      @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0; settle();

      // Counter wrap after 65536 completed responses
      @(negedge clk); rst = 1'b1; settle();
      @(negedge clk); settle();
      q.delete();
      rst = 1'b0;
      for (int c = 1; c <= 65536; c++) begin
         @(negedge clk);
         set_req(1'b0, ALU_ADD, c, 32'd0, 32'd1, 1'b0);
         settle();
      end
      @(negedge clk); r0_valid = 1'b0; settle();
      chk("count_ffff", op_count_a, 16'hFFFF);
      @(negedge clk); settle();
      chk("count_wrap", op_count_a, 16'h0000);
      @(negedge clk); settle();
      chk("sb_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
